// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-style memory slave.
// m0 is read-only instruction fetch, m1 is read/write data; stalls are bounded by a timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    output logic        bus_error
);

    // state | meaning
    // IDLE  | no transfer; arbitrate pending requests
    // BUSY  | granted master connected to the slave
    // ABORT | one-cycle timeout abort, bus_error asserted

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;   // 0 = m0, 1 = m1
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic m0_req, m1_req, gnt_req;

    assign m0_req  = m0_read;
    assign m1_req  = m1_read | m1_write;
    assign gnt_req = grant_q ? m1_req : m0_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ST_BUSY;
                    grant_d = (m0_req && m1_req) ? ~last_q : m1_req;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                // A master dropping its request mid-stall is a protocol violation; release quietly.
                if (!s_waitrequest || !gnt_req) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d = ST_ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                last_d  = grant_q;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = m0_req;
        m1_waitrequest = m1_req;
        bus_error      = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (!grant_q) begin
                    s_address      = m0_address;
                    s_read         = m0_read;
                    m0_waitrequest = s_waitrequest;
                    m0_readdata    = s_readdata;
                end else begin
                    // Simultaneous read and write from m1 is treated as a write.
                    s_address      = m1_address;
                    s_read         = m1_read & ~m1_write;
                    s_write        = m1_write;
                    s_writedata    = m1_writedata;
                    m1_waitrequest = s_waitrequest;
                    m1_readdata    = s_readdata;
                end
            end
            ST_ABORT: begin
                bus_error = 1'b1;
                if (!grant_q) m0_waitrequest = 1'b0;
                else          m1_waitrequest = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
